vlsu_req_sched: RTL and testbench

- Request scheduler in front of the VLSU control machine.
- Shares the single vlsu request port between NrReq requesters using a locked round-robin arbiter.
- Enforces store ordering: tracks outstanding stores, holds fenced requests until every prior store completes, and throttles stores at a credit limit.
- Drives the control machine's request handshake and core_st_pending-style indication.

---
 rtl/vlsu_req_sched.sv | 145 ++++++++++++++
 tb/tb_vlsu_req_sched.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vlsu_req_sched.sv
// Request scheduler in front of the VLSU control machine: a locked round-robin
// arbiter over NrReq requesters with store credit tracking and fence ordering.
module vlsu_req_sched #(
  parameter int unsigned NrReq      = 2,
  parameter int unsigned MaxOutstSt = 8,
  parameter type         vlsu_req_t = logic
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NrReq-1:0]         req_valid_i,
  output logic [NrReq-1:0]         req_ready_o,
  input  vlsu_req_t                req_i [NrReq],
  input  logic [NrReq-1:0]         req_is_store_i,
  input  logic [NrReq-1:0]         req_fence_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output vlsu_req_t                out_req_o,
  output logic [$clog2(NrReq)-1:0] out_id_o,
  input  logic                     st_done_i,
  output logic [7:0]               st_outst_o,
  output logic                     st_pending_o,
  output logic                     err_o
);

  localparam int unsigned IdW   = $clog2(NrReq);
  localparam logic [7:0]  MaxSt = 8'(MaxOutstSt);

  typedef logic [IdW-1:0] id_t;
  typedef enum logic {IDLE, LOCK} state_e;

  state_e     state_q;
  id_t        ptr_q;
  id_t        lock_id_q;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic       pend_q;
  logic       err_q;
  logic       underflow;

  logic [NrReq-1:0] elig;
  logic             pick_valid;
  id_t              pick_id;
  logic             gnt_valid;
  id_t              gnt_id;
  logic             hs_st;

  function automatic id_t next_ptr(input id_t id);
    return (id == id_t'(NrReq - 1)) ? '0 : id + id_t'(1);
  endfunction

  // Eligibility reads the registered count, so a completion never releases a
  // fence or a credit within its own cycle.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    elig       = '0;
    pick_valid = 1'b0;
    pick_id    = '0;
    for (int i = 0; i < NrReq; i++) begin
      elig[i] = req_valid_i[i]
              & (~req_fence_i[i]    | (cnt_q == 8'd0))
              & (~req_is_store_i[i] | (cnt_q < MaxSt));
    end
    for (int k = 0; k < NrReq; k++) begin
      id_t cand;
      cand = id_t'((int'(ptr_q) + k) % int'(NrReq));
      if (!pick_valid && elig[cand]) begin
        pick_valid = 1'b1;
        pick_id    = cand;
      end
    end
  end

  // The IDLE grant is combinational, so outputs are masked by rst_i to read
  // inactive for the whole time reset is held, not just after the next edge.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = '0;
    if (state_q == LOCK) begin
      gnt_valid = 1'b1;
      gnt_id    = lock_id_q;
    end else if (pick_valid) begin
      gnt_valid = 1'b1;
      gnt_id    = pick_id;
    end
    out_valid_o = gnt_valid & ~rst_i;
    out_id_o    = rst_i ? '0 : gnt_id;
    out_req_o   = rst_i ? '0 : req_i[gnt_id];
    req_ready_o = '0;
    if (out_valid_o) req_ready_o[gnt_id] = out_ready_i;
    hs_st = out_valid_o & out_ready_i & req_is_store_i[gnt_id];
  end

  always_comb begin
    cnt_d     = cnt_q;
    underflow = 1'b0;
    case ({hs_st, st_done_i})
      2'b10: cnt_d = cnt_q + 8'd1;
      2'b01: begin
        if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
        else               underflow = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      lock_id_q <= '0;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= (cnt_d != 8'd0);
      err_q  <= err_q | underflow;
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            if (out_ready_i) begin
              ptr_q <= next_ptr(pick_id);
            end else begin
              lock_id_q <= pick_id;
              state_q   <= LOCK;
            end
          end
        end
        LOCK: begin
          if (out_ready_i) begin
            ptr_q   <= next_ptr(lock_id_q);
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign st_outst_o   = cnt_q;
  assign st_pending_o = pend_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_vlsu_req_sched.sv
// Self-checking bench for vlsu_req_sched: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
module tb_vlsu_req_sched;

  localparam int NR    = 2;
  localparam int MAXST = 2;
  typedef logic [0:0]  id_t;
  typedef logic [15:0] pay_t;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [1:0] req_valid_i;
  logic [1:0] req_ready_o;
  pay_t       req_pay [NR];
  logic [1:0] req_is_store_i;
  logic [1:0] req_fence_i;
  logic       out_valid_o;
  logic       out_ready_i;
  pay_t       out_req_o;
  logic [0:0] out_id_o;
  logic       st_done_i;
  logic [7:0] st_outst_o;
  logic       st_pending_o;
  logic       err_o;

  vlsu_req_sched #(.NrReq(NR), .MaxOutstSt(MAXST), .vlsu_req_t(pay_t)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_i(req_pay),
    .req_is_store_i(req_is_store_i), .req_fence_i(req_fence_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_req_o(out_req_o), .out_id_o(out_id_o),
    .st_done_i(st_done_i), .st_outst_o(st_outst_o),
    .st_pending_o(st_pending_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: pending transaction, rotating priority, store credits.
  int   m_ptr, m_cnt;
  bit   m_err, m_locked, m_lst, m_lfe;
  id_t  m_lid;
  pay_t m_lpay;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_cnt = 0; m_err = 0; m_locked = 0;
    m_lst = 0; m_lfe = 0; m_lid = '0; m_lpay = '0;
  endtask

  task automatic drive_idle();
    req_valid_i = '0; req_is_store_i = '0; req_fence_i = '0;
    req_pay[0] = '0; req_pay[1] = '0; out_ready_i = 1'b0; st_done_i = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(out_valid_o), 32'd0);
    check({tag, "_ready"}, 32'(req_ready_o), 32'd0);
    check({tag, "_id"},    32'(out_id_o),    32'd0);
    check({tag, "_outst"}, 32'(st_outst_o),  32'd0);
    check({tag, "_pend"},  32'(st_pending_o), 32'd0);
    check({tag, "_err"},   32'(err_o),       32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    drive_idle();
    #1;
    check_reset_outputs("rst");
    @(negedge clk_i);
    rst_i = 1'b0;
    model_reset();
  endtask

  // One clock cycle: drive at negedge, compare settled outputs, update model at posedge.
  task automatic step(input logic [1:0] v, input logic [1:0] st, input logic [1:0] fe,
                      input pay_t p0, input pay_t p1, input logic rdy, input logic done,
                      output logic o_valid, output int o_id, output int o_cnt);
    pay_t       p [NR];
    bit         exp_valid, hs, hs_st;
    id_t        exp_id;
    logic [1:0] exp_rdy;
    p[0] = p0; p[1] = p1;
    @(negedge clk_i);
    if (m_locked) begin
      v[m_lid] = 1'b1; st[m_lid] = m_lst; fe[m_lid] = m_lfe; p[m_lid] = m_lpay;
    end
    req_valid_i = v; req_is_store_i = st; req_fence_i = fe;
    req_pay[0] = p[0]; req_pay[1] = p[1];
    out_ready_i = rdy; st_done_i = done;
    #1;
    exp_valid = 0;
    exp_id    = '0;
    if (m_locked) begin
      exp_valid = 1; exp_id = m_lid;
    end else begin
      for (int k = 0; k < NR; k++) begin
        id_t i;
        i = id_t'((m_ptr + k) % NR);
        if (!exp_valid && v[i] && (!fe[i] || m_cnt == 0) && (!st[i] || m_cnt < MAXST)) begin
          exp_valid = 1; exp_id = i;
        end
      end
    end
    exp_rdy = '0;
    if (exp_valid && rdy) exp_rdy[exp_id] = 1'b1;
    check("out_valid", 32'(out_valid_o), 32'(exp_valid));
    check("req_ready", 32'(req_ready_o), 32'(exp_rdy));
    if (exp_valid) begin
      check("out_id",  32'(out_id_o),  32'(exp_id));
      check("out_req", 32'(out_req_o), 32'(p[exp_id]));
    end
    check("st_outst",   32'(st_outst_o),   32'(m_cnt));
    check("st_pending", 32'(st_pending_o), 32'(m_cnt != 0));
    check("err",        32'(err_o),        32'(m_err));
    o_valid = out_valid_o;
    o_id    = int'(out_id_o);
    @(posedge clk_i);
    hs    = exp_valid && rdy;
    hs_st = hs && st[exp_id];
    if (hs) begin
      m_ptr    = (int'(exp_id) + 1) % NR;
      m_locked = 0;
    end else if (exp_valid && !m_locked) begin
      m_locked = 1; m_lid = exp_id; m_lst = st[exp_id]; m_lfe = fe[exp_id]; m_lpay = p[exp_id];
    end
    if (hs_st && !done) m_cnt++;
    else if (!hs_st && done) begin
      if (m_cnt > 0) m_cnt--;
      else m_err = 1;
    end
    #1;
    o_cnt = int'(st_outst_o);
  endtask

  logic o_v;
  int   o_id, o_cnt;

  initial begin
    rst_i = 1'b1;
    drive_idle();
    model_reset();
    #1;
    check_reset_outputs("por");
    do_reset();

    // Single load on requester 0 with ready: same-cycle handshake, then pointer at 1.
    step(2'b01, 2'b00, 2'b00, 16'h1111, 16'h0, 1'b1, 1'b0, o_v, o_id, o_cnt);
    check("single_id", 32'(o_id), 32'd0);
    check("single_cnt", 32'(o_cnt), 32'd0);
    step(2'b11, 2'b00, 2'b00, 16'h1234, 16'h5678, 1'b0, 1'b0, o_v, o_id, o_cnt);
    check("ptr_after_single", 32'(o_id), 32'd1);

    // Alternation from reset.
    do_reset();
    for (int c = 0; c < 4; c++) begin
      step(2'b11, 2'b00, 2'b00, 16'hA000, 16'hB000, 1'b1, 1'b0, o_v, o_id, o_cnt);
      check("alternate", 32'(o_id), 32'(c % 2));
    end

    // Lock on requester 1 while requester 0 arrives.
    do_reset();
    step(2'b10, 2'b00, 2'b00, 16'h0, 16'hCAFE, 1'b0, 1'b0, o_v, o_id, o_cnt);
    check("lock_id0", 32'(o_id), 32'd1);
    for (int c = 0; c < 2; c++) begin
      step(2'b11, 2'b00, 2'b00, 16'h0BAD, 16'hCAFE, 1'b0, 1'b0, o_v, o_id, o_cnt);
      check("lock_hold", 32'(o_id), 32'd1);
    end
    step(2'b11, 2'b00, 2'b00, 16'h0BAD, 16'hCAFE, 1'b1, 1'b0, o_v, o_id, o_cnt);
    check("lock_release", 32'(o_id), 32'd1);
    step(2'b01, 2'b00, 2'b00, 16'h0BAD, 16'h0, 1'b1, 1'b0, o_v, o_id, o_cnt);
    check("after_lock", 32'(o_id), 32'd0);

    // Store credit limit of 2.
    do_reset();
    step(2'b01, 2'b01, 2'b00, 16'h5001, 16'h0, 1'b1, 1'b0, o_v, o_id, o_cnt);
    step(2'b01, 2'b01, 2'b00, 16'h5002, 16'h0, 1'b1, 1'b0, o_v, o_id, o_cnt);
    check("credit_full", 32'(o_cnt), 32'd2);
    step(2'b01, 2'b01, 2'b00, 16'h5003, 16'h0, 1'b1, 1'b0, o_v, o_id, o_cnt);
    check("credit_block", 32'(o_v), 32'd0);
    step(2'b01, 2'b01, 2'b00, 16'h5003, 16'h0, 1'b1, 1'b1, o_v, o_id, o_cnt);
    check("credit_block_done", 32'(o_v), 32'd0);
    check("credit_dec", 32'(o_cnt), 32'd1);
    step(2'b01, 2'b01, 2'b00, 16'h5003, 16'h0, 1'b1, 1'b0, o_v, o_id, o_cnt);
    check("credit_regrant", 32'(o_v), 32'd1);
    check("credit_refill", 32'(o_cnt), 32'd2);

    // Fenced load waits for both stores to retire, released a cycle later.
    step(2'b10, 2'b00, 2'b10, 16'h0, 16'hFE00, 1'b1, 1'b0, o_v, o_id, o_cnt);
    check("fence_hold0", 32'(o_v), 32'd0);
    step(2'b10, 2'b00, 2'b10, 16'h0, 16'hFE00, 1'b1, 1'b1, o_v, o_id, o_cnt);
    check("fence_hold1", 32'(o_v), 32'd0);
    step(2'b10, 2'b00, 2'b10, 16'h0, 16'hFE00, 1'b1, 1'b1, o_v, o_id, o_cnt);
    check("fence_same_cycle", 32'(o_v), 32'd0);
    check("fence_cnt0", 32'(o_cnt), 32'd0);
    step(2'b10, 2'b00, 2'b10, 16'h0, 16'hFE00, 1'b1, 1'b0, o_v, o_id, o_cnt);
    check("fence_release", 32'(o_v), 32'd1);
    check("fence_release_id", 32'(o_id), 32'd1);
    step(2'b01, 2'b01, 2'b00, 16'h5100, 16'h0, 1'b1, 1'b0, o_v, o_id, o_cnt);
    step(2'b01, 2'b01, 2'b00, 16'h5101, 16'h0, 1'b1, 1'b1, o_v, o_id, o_cnt);
    check("st_and_done", 32'(o_cnt), 32'd1);
    step(2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 1'b0, 1'b1, o_v, o_id, o_cnt);

    // Underflow is sticky; reset while locked clears everything at once.
    step(2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 1'b0, 1'b1, o_v, o_id, o_cnt);
    check("underflow_cnt", 32'(o_cnt), 32'd0);
    check("underflow_err", 32'(err_o), 32'd1);
    step(2'b01, 2'b00, 2'b00, 16'h7777, 16'h0, 1'b0, 1'b0, o_v, o_id, o_cnt);
    @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    check_reset_outputs("rst_in_lock");
    @(negedge clk_i);
    rst_i = 1'b0;
    drive_idle();
    model_reset();

    // Randomized traffic against the model, with one reset in the middle.
    for (int c = 0; c < 600; c++) begin
      logic [1:0] fe;
      if (c == 300) do_reset();
      fe = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00;
      step(2'($urandom), 2'($urandom), fe, 16'($urandom), 16'($urandom),
           1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), o_v, o_id, o_cnt);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
